maf_norm_round: RTL

- Final stage of the single-precision multiply-add-fused pipeline. It sits directly downstream of the T4 pipeline register and consumes its outputs: 74-bit sum magnitude, LZA shift count, special-case code and revise flags.
- Performs a normalization left shift and a one-bit LZA correction, rounds to 24 bits and packs the IEEE-754 single result.
- Two-stage pipeline with a valid/ready handshake, so the MAF can be stalled by its consumer.

---
 rtl/maf_norm_round_if.sv | 34 +++
 rtl/maf_norm_round.sv | 138 +++++++++++++
 2 files changed

// File: rtl/maf_norm_round_if.sv
// Beat and result channels of the MAF normalize/round stage.
// With MAF_ROUND_MODES_EN defined the beat also carries a 2-bit rounding mode rm.
interface maf_norm_round_if #(
  parameter int unsigned PW = 74,
  parameter int unsigned SW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic          sign;
  logic [SW-1:0] e_in;
  logic [PW-1:0] p_reg;
  logic [SW-1:0] sh_num;
  logic [1:0]    esh;
  logic [1:0]    revi;
`ifdef MAF_ROUND_MODES_EN
  logic [1:0]    rm;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   result;
  logic [2:0]    flags;

`ifdef MAF_ROUND_MODES_EN
  modport master (output in_valid, sign, e_in, p_reg, sh_num, esh, revi, rm, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, sign, e_in, p_reg, sh_num, esh, revi, rm, out_ready,
                  output in_ready, out_valid, result, flags);
`else
  modport master (output in_valid, sign, e_in, p_reg, sh_num, esh, revi, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, sign, e_in, p_reg, sh_num, esh, revi, out_ready,
                  output in_ready, out_valid, result, flags);
`endif
endinterface

// File: rtl/maf_norm_round.sv
// MAF final stage: normalize shift with LZA correction, round to 24 bits, pack IEEE single.
// Optional MAF_ROUND_MODES_EN adds per-beat rounding modes (RNE/RTZ/+inf/-inf); default is RNE only.
module maf_norm_round #(
  parameter int unsigned PW = 74,
  parameter int unsigned SW = 10
) (
  input  logic            clk,
  input  logic            rstn,
  maf_norm_round_if.slave bus
);
  localparam int unsigned KW = 26;      // 24 significand bits + guard + round
  localparam int unsigned EW = SW + 1;
  localparam logic signed [EW:0] E_MAX  = (EW+1)'(255);
  localparam logic signed [EW:0] E_ZERO = '0;

  logic          a_vld, b_vld, a_adv, b_adv;
  logic [KW-1:0] a_m;
  logic          a_sticky, a_mz, a_sign;
  logic [EW-1:0] a_e;
  logic [1:0]    a_esh;
`ifdef MAF_ROUND_MODES_EN
  logic [1:0]    a_rm;
`endif
  logic [31:0]   res_q;
  logic [2:0]    flg_q;

  assign b_adv         = !b_vld || bus.out_ready;
  assign a_adv         = !a_vld || b_adv;
  assign bus.in_ready  = a_adv;
  assign bus.out_valid = b_vld;
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;

  // Stage A: normalize shift, one-bit LZA fix-up, exponent adjust
  logic [PW-1:0] sh_m, m_c;
  logic          corr_c;
  logic [EW-1:0] e_a_c;
  always_comb begin
    sh_m   = (bus.sh_num > SW'(PW-1)) ? '0 : (bus.p_reg << bus.sh_num);
    corr_c = bus.revi[0] & ~sh_m[PW-1];
    m_c    = corr_c ? (sh_m << 1) : sh_m;
    e_a_c  = {bus.e_in[SW-1], bus.e_in} - {1'b0, bus.sh_num} - EW'(corr_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_vld    <= 1'b0;
      a_m      <= '0;
      a_sticky <= 1'b0;
      a_mz     <= 1'b0;
      a_e      <= '0;
      a_sign   <= 1'b0;
      a_esh    <= '0;
`ifdef MAF_ROUND_MODES_EN
      a_rm     <= '0;
`endif
    end else if (a_adv) begin
      a_vld <= bus.in_valid;
      if (bus.in_valid) begin
        a_m      <= m_c[PW-1 -: KW];
        a_sticky <= (|m_c[PW-KW-1:0]) | bus.revi[1];
        a_mz     <= (m_c == '0);
        a_e      <= e_a_c;
        a_sign   <= bus.sign;
        a_esh    <= bus.esh;
`ifdef MAF_ROUND_MODES_EN
        a_rm     <= bus.rm;
`endif
      end
    end
  end

  // Stage B: round, exponent range checks, special-case packing
  logic [23:0]        sig;
  logic               g, s, rup, away, carry;
  logic [24:0]        sum;
  logic [22:0]        frac;
  logic signed [EW:0] e_f;
  logic [31:0]        res_c;
  logic [2:0]         flg_c;
  always_comb begin
    sig = a_m[KW-1:2];
    g   = a_m[1];
    s   = a_m[0] | a_sticky;
`ifdef MAF_ROUND_MODES_EN
    case (a_rm)
      2'b00:   rup = g & (s | sig[0]);
      2'b01:   rup = 1'b0;
      2'b10:   rup = (g | s) & ~a_sign;
      default: rup = (g | s) & a_sign;
    endcase
    away = (a_rm == 2'b00) || (a_rm == 2'b10 && !a_sign) || (a_rm == 2'b11 && a_sign);
`else
    rup  = g & (s | sig[0]);
    away = 1'b1;
`endif
    sum   = {1'b0, sig} + 25'(rup);
    carry = sum[24];
    frac  = carry ? '0 : sum[22:0];
    e_f   = signed'({a_e[EW-1], a_e} + (EW+1)'(carry));
    res_c = '0;
    flg_c = '0;
    case (a_esh)
      2'b01:   res_c = {a_sign, 31'd0};
      2'b10:   res_c = {a_sign, 8'hFF, 23'd0};
      2'b11:   res_c = 32'h7FC0_0000;
      default: begin
        if (a_mz) begin
          res_c = {a_sign, 31'd0};
        end else if (e_f >= E_MAX) begin
          res_c = away ? {a_sign, 8'hFF, 23'd0} : {a_sign, 31'h7F7F_FFFF};
          flg_c = 3'b101;
        end else if (e_f <= E_ZERO) begin
          res_c = {a_sign, 31'd0};
          flg_c = 3'b011;
        end else begin
          res_c = {a_sign, e_f[7:0], frac};
          flg_c = {2'b00, g | s};
        end
      end
    endcase
  end

  // Output register holds while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_vld <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else if (b_adv) begin
      b_vld <= a_vld;
      if (a_vld) begin
        res_q <= res_c;
        flg_q <= flg_c;
      end
    end
  end
endmodule
